// File: rtl/mips_lsu.sv
// Load/store unit: drives the word-wide data memory for one load or store at
// a time. Sub-word loads are extracted and extended here; sub-word stores are
// done as read-modify-write because the memory only writes whole words.
module mips_lsu #(
   parameter int unsigned ADDR_LIMIT = 1024,
   parameter bit          WR_SWAP    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] write_data,
   output logic        sig_mem_read,
   output logic        sig_mem_write,
   input  logic [31:0] read_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;

   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  off_q;
   logic [31:0] wreq_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic [2:0]  req_bytes;
   logic [32:0] req_end;
   logic        req_misalign;
   logic        req_err;

   // Full byte reversal of a word.
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // The memory wants write words lane-reversed relative to the big-endian
   // view used everywhere inside this unit.
   function automatic logic [31:0] present_word(input logic [31:0] w);
      return WR_SWAP ? bswap(w) : w;
   endfunction

   // Pick the addressed byte/halfword out of a big-endian read word and
   // extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
      logic        [7:0]  b;
      logic        [15:0] h;
      logic        [31:0] r;
      case (off)
         2'd0:    b = rd[31:24];
         2'd1:    b = rd[23:16];
         2'd2:    b = rd[15:8];
         default: b = rd[7:0];
      endcase
      h = off[1] ? rd[15:0] : rd[31:16];
      case (size)
         2'd0:    r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
         2'd1:    r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   // Overlay the store data onto the sampled word, keeping untouched lanes.
   function automatic logic [31:0] store_merge(input logic [31:0] rd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] wd);
      logic [31:0] m;
      m = rd;
      if (size == 2'd0) begin
         case (off)
            2'd0:    m[31:24] = wd[7:0];
            2'd1:    m[23:16] = wd[7:0];
            2'd2:    m[15:8]  = wd[7:0];
            default: m[7:0]   = wd[7:0];
         endcase
      end else if (size == 2'd1) begin
         if (off[1]) m[15:0]  = wd[15:0];
         else        m[31:16] = wd[15:0];
      end else begin
         m = wd;
      end
      return m;
   endfunction

   // Classify the incoming request: alignment, reserved size and range.
   always_comb begin
      req_bytes    = 3'd4;
      req_misalign = 1'b0;
      case (req_size)
         2'd0: req_bytes = 3'd1;
         2'd1: begin
            req_bytes    = 3'd2;
            req_misalign = req_addr[0];
         end
         2'd2: begin
            req_bytes    = 3'd4;
            req_misalign = |req_addr[1:0];
         end
         default: req_bytes = 3'd4;
      endcase
      req_end = {1'b0, req_addr} + {30'd0, req_bytes};
      req_err = (req_size == 2'd3) || req_misalign || (req_end > 33'(ADDR_LIMIT));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: errors skip the memory entirely, word stores skip the read.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_err)                        state_d = S_RESP;
               else if (req_we && req_size == 2'd2) state_d = S_WRITE;
               else                                 state_d = S_READ;
            end
         end
         S_READ:  state_d = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the state; address and write word come from registers.
   always_comb begin
      req_ready     = (state_q == S_IDLE);
      sig_mem_read  = (state_q == S_READ);
      sig_mem_write = (state_q == S_WRITE);
      resp_valid    = (state_q == S_RESP);
      resp_err      = (state_q == S_RESP) && err_q;
      resp_rdata    = (state_q == S_RESP) ? rdata_q : 32'd0;
      mem_address   = addr_q;
      write_data    = wdata_q;
   end

   // Request latch, read sampling and write-word construction.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         off_q    <= 2'd0;
         wreq_q   <= 32'd0;
         err_q    <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  off_q    <= req_addr[1:0];
                  wreq_q   <= req_wdata;
                  err_q    <= req_err;
                  rdata_q  <= 32'd0;
                  if (!req_err) begin
                     addr_q <= {req_addr[31:2], 2'b00};
                     if (req_we && req_size == 2'd2)
                        wdata_q <= present_word(req_wdata);
                  end
               end
            end
            S_READ: begin
               if (we_q) wdata_q <= present_word(store_merge(read_data, size_q, off_q, wreq_q));
               else      rdata_q <= load_extract(read_data, size_q, off_q, signed_q);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a word-wide behavioural data memory.
module tb_mips_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic [31:0] write_data;
   logic        sig_mem_read;
   logic        sig_mem_write;
   logic [31:0] read_data;

   logic [31:0] mem [0:255];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_idx = 8'd0;
   logic [31:0] tb_val = 32'd0;

   logic [1:6]  p_rd, p_wr, p_rv, p_re, p_rdy;
   logic [31:0] c_rdat [1:6];
   logic [31:0] c_wd   [1:6];
   logic [31:0] c_ma   [1:6];

   int total  = 0;
   int passed = 0;

   mips_lsu #(.ADDR_LIMIT(1024), .WR_SWAP(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .mem_address(mem_address), .write_data(write_data),
      .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
      .read_data(read_data)
   );

   always #5 clk = ~clk;

   // Big-endian memory: reads are combinational, writes arrive lane-reversed.
   assign read_data = mem[mem_address[9:2]];
   always @(posedge clk) begin
      if (sig_mem_write)
         mem[mem_address[9:2]] <= {write_data[7:0], write_data[15:8],
                                   write_data[23:16], write_data[31:24]};
      else if (tb_we)
         mem[tb_idx] <= tb_val;
   end

   task automatic poke(input logic [31:0] byte_addr, input logic [31:0] val);
      tb_idx = byte_addr[9:2];
      tb_val = val;
      tb_we  = 1'b1;
      @(posedge clk); #1;
      tb_we  = 1'b0;
   endtask

   // Issue one request from idle and record the six cycles after the accept edge.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic hold);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         p_rd[i] = sig_mem_read;  p_wr[i] = sig_mem_write;
         p_rv[i] = resp_valid;    p_re[i] = resp_err;  p_rdy[i] = req_ready;
         c_rdat[i] = resp_rdata;  c_wd[i] = write_data; c_ma[i] = mem_address;
         if (i == 6) req_valid = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passed++;
      total++; if ({resp_valid, resp_err, sig_mem_read, sig_mem_write} !== 4'b0000)
         $display("FAIL rst_flags: got %b want 0000", {resp_valid, resp_err, sig_mem_read, sig_mem_write}); else passed++;
      total++; if ({resp_rdata, mem_address, write_data} !== 96'd0)
         $display("FAIL rst_data: got %h %h %h want zeros", resp_rdata, mem_address, write_data); else passed++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_word();
      poke(32'h10, 32'h11223344);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
      total++; if (p_rd !== 6'b100000) $display("FAIL lw_rd_strobe: got %b want 100000", p_rd); else passed++;
      total++; if (p_wr !== 6'b000000) $display("FAIL lw_wr_strobe: got %b want 000000", p_wr); else passed++;
      total++; if (c_ma[1] !== 32'h10) $display("FAIL lw_addr: got %h want 00000010", c_ma[1]); else passed++;
      total++; if (p_rv !== 6'b010000) $display("FAIL lw_resp_valid: got %b want 010000", p_rv); else passed++;
      total++; if (p_re !== 6'b000000) $display("FAIL lw_resp_err: got %b want 000000", p_re); else passed++;
      total++; if (c_rdat[2] !== 32'h11223344) $display("FAIL lw_rdata: got %h want 11223344", c_rdat[2]); else passed++;
      total++; if (p_rdy !== 6'b001111) $display("FAIL lw_ready: got %b want 001111", p_rdy); else passed++;
   endtask

   task automatic test_load_ext();
      poke(32'h10, 32'h112233C4);
      poke(32'h14, 32'h8001F00F);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'hFFFFFFC4) $display("FAIL lb_signed: got %h want FFFFFFC4", c_rdat[2]); else passed++;
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h000000C4) $display("FAIL lbu: got %h want 000000C4", c_rdat[2]); else passed++;
      do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h00001122) $display("FAIL lh_pos: got %h want 00001122", c_rdat[2]); else passed++;
      do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h00000022) $display("FAIL lbu_off1: got %h want 00000022", c_rdat[2]); else passed++;
      do_req(1'b0, 2'd1, 1'b1, 32'h16, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'hFFFFF00F) $display("FAIL lh_neg_off2: got %h want FFFFF00F", c_rdat[2]); else passed++;
      do_req(1'b0, 2'd1, 1'b0, 32'h14, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h00008001) $display("FAIL lhu_off0: got %h want 00008001", c_rdat[2]); else passed++;
   endtask

   task automatic test_store_sub();
      poke(32'h10, 32'h11223344);
      do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 1'b0);
      total++; if (p_rd !== 6'b100000) $display("FAIL sh_rd_strobe: got %b want 100000", p_rd); else passed++;
      total++; if (p_wr !== 6'b010000) $display("FAIL sh_wr_strobe: got %b want 010000", p_wr); else passed++;
      total++; if (c_wd[2] !== 32'hCDAB2211) $display("FAIL sh_wdata: got %h want CDAB2211", c_wd[2]); else passed++;
      total++; if (c_ma[2] !== 32'h10 || c_ma[1] !== 32'h10) $display("FAIL sh_addr: got %h/%h want 00000010", c_ma[1], c_ma[2]); else passed++;
      total++; if (p_rv !== 6'b001000) $display("FAIL sh_resp_valid: got %b want 001000", p_rv); else passed++;
      total++; if (c_rdat[3] !== 32'd0 || p_re[3] !== 1'b0) $display("FAIL sh_resp: got %h err %b want 0 err 0", c_rdat[3], p_re[3]); else passed++;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h1122ABCD) $display("FAIL sh_readback: got %h want 1122ABCD", c_rdat[2]); else passed++;
      do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456EE, 1'b0);
      total++; if (c_wd[2] !== 32'hCDABEE11) $display("FAIL sb_wdata: got %h want CDABEE11", c_wd[2]); else passed++;
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'h11EEABCD) $display("FAIL sb_readback: got %h want 11EEABCD", c_rdat[2]); else passed++;
   endtask

   task automatic test_word_store();
      do_req(1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEADBEEF, 1'b0);
      total++; if (p_wr !== 6'b100000 || p_rd !== 6'b000000) $display("FAIL sw_strobes: got rd %b wr %b want 000000/100000", p_rd, p_wr); else passed++;
      total++; if (c_wd[1] !== 32'hEFBEADDE) $display("FAIL sw_wdata: got %h want EFBEADDE", c_wd[1]); else passed++;
      total++; if (p_rv !== 6'b010000 || p_re !== 6'b000000) $display("FAIL sw_resp: got v %b e %b want 010000/000000", p_rv, p_re); else passed++;
      do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, 1'b0);
      total++; if (c_rdat[2] !== 32'hDEADBEEF) $display("FAIL sw_readback: got %h want DEADBEEF", c_rdat[2]); else passed++;
   endtask

   task automatic test_errors();
      do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, 1'b0);
      total++; if (p_rv !== 6'b100000 || p_re !== 6'b100000) $display("FAIL err_lw_mis: got v %b e %b want 100000", p_rv, p_re); else passed++;
      total++; if ((p_rd | p_wr) !== 6'b000000 || c_rdat[1] !== 32'd0) $display("FAIL err_lw_mis_side: got strobes %b rdata %h want 0", p_rd | p_wr, c_rdat[1]); else passed++;
      do_req(1'b1, 2'd2, 1'b0, 32'h3FE, 32'h12345678, 1'b0);
      total++; if (p_re !== 6'b100000 || (p_rd | p_wr) !== 6'b000000) $display("FAIL err_sw_3fe: got e %b strobes %b", p_re, p_rd | p_wr); else passed++;
      do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0);
      total++; if (p_re !== 6'b100000 || (p_rd | p_wr) !== 6'b000000 || c_rdat[1] !== 32'd0) $display("FAIL err_size3: got e %b strobes %b rdata %h", p_re, p_rd | p_wr, c_rdat[1]); else passed++;
      do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 1'b0);
      total++; if (p_re !== 6'b100000 || (p_rd | p_wr) !== 6'b000000) $display("FAIL err_sw_400: got e %b strobes %b", p_re, p_rd | p_wr); else passed++;
      do_req(1'b0, 2'd0, 1'b0, 32'h3FF, 32'd0, 1'b0);
      total++; if (p_re !== 6'b000000 || c_rdat[2] !== 32'h000000EF) $display("FAIL lb_3ff_edge: got e %b rdata %h want 0/000000EF", p_re, c_rdat[2]); else passed++;
   endtask

   task automatic test_back_to_back();
      do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0, 1'b1);
      total++; if (p_rv !== 6'b010010) $display("FAIL b2b_resp_valid: got %b want 010010", p_rv); else passed++;
      total++; if (p_rd !== 6'b100100) $display("FAIL b2b_rd_strobe: got %b want 100100", p_rd); else passed++;
      total++; if (p_rdy !== 6'b001001) $display("FAIL b2b_ready: got %b want 001001", p_rdy); else passed++;
      total++; if (c_rdat[5] !== 32'hDEADBEEF) $display("FAIL b2b_rdata: got %h want DEADBEEF", c_rdat[5]); else passed++;
   endtask

   task automatic test_reset_midflight();
      logic wr_seen;
      poke(32'h20, 32'hA5A5A5A5);
      req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h00000077;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++; if (sig_mem_read !== 1'b1) $display("FAIL mid_in_read: got %b want 1", sig_mem_read); else passed++;
      rst = 1'b1;
      @(posedge clk); #1;
      wr_seen = sig_mem_write;
      total++; if ({resp_valid, resp_err, sig_mem_read, sig_mem_write} !== 4'b0000 || {resp_rdata, mem_address, write_data} !== 96'd0)
         $display("FAIL mid_outputs: got flags %b data %h %h %h want zeros", {resp_valid, resp_err, sig_mem_read, sig_mem_write}, resp_rdata, mem_address, write_data); else passed++;
      @(posedge clk); #1;
      wr_seen = wr_seen | sig_mem_write;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         wr_seen = wr_seen | sig_mem_write;
      end
      total++; if (wr_seen !== 1'b0) $display("FAIL mid_no_write: got %b want 0", wr_seen); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready); else passed++;
      total++; if (mem[8] !== 32'hA5A5A5A5) $display("FAIL mid_mem: got %h want A5A5A5A5", mem[8]); else passed++;
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_ext();
      test_store_sub();
      test_word_store();
      test_errors();
      test_back_to_back();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Load/store unit: the initiator side of the data-memory interface. It accepts one load or store request at a time from the pipeline and drives the word-wide data memory through a short FSM. It extracts bytes and halfwords on loads, with sign or zero extension, and performs read-modify-write for sub-word stores, because the data memory only writes full words. It sits between the MEM stage and the data memory.

Parameters:
ADDR_LIMIT, 1024, size of the data memory in bytes; an access whose last byte is at or beyond this address is an error.
WR_SWAP, 1, 1 = present write words byte-reversed to the memory (data-memory lane contract, see Behaviour); 0 = present unchanged.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  unit idle and able to accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (error)
req_signed  input  1  load sign-extend (1) or zero-extend (0)
req_addr  input  32  byte address
req_wdata  input  32  store data; byte uses [7:0], halfword uses [15:0]
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or reserved size
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors
mem_address  output  32  word-aligned address to the data memory
write_data  output  32  word to the data memory
sig_mem_read  output  1  memory read strobe
sig_mem_write  output  1  memory write strobe
read_data  input  32  combinational read word from the data memory

Behaviour:
- Memory contract:
  - Read word is big-endian: the byte at offset k is read_data[31-8k -: 8].
  - Write word is lane-reversed: the byte at offset k goes in write_data[8k+7 : 8k].
  - With WR_SWAP=1, the unit builds the big-endian word W and drives write_data = byteswap(W).
- Reset: on a clk edge with rst=1:
  - State goes to IDLE.
  - req_ready=1 after the edge.
  - resp_valid, resp_err, resp_rdata, sig_mem_read, sig_mem_write, mem_address and write_data all go to 0.
  - Any in-flight request is dropped. No write is issued after the reset edge.
- FSM states are IDLE, READ, WRITE and RESP.
  - req_ready = (state==IDLE).
  - A request is accepted on an edge where req_valid && req_ready. Address, size, signed and data are latched at that edge.
- Error check at accept:
  - Errors are halfword with addr[0]≠0, word with addr[1:0]≠0, size=3, or addr+bytes > ADDR_LIMIT.
  - On error: go to RESP with resp_err=1. No memory strobe is ever asserted.
- Load: IDLE → READ (sig_mem_read=1 for exactly one cycle, mem_address={addr[31:2],2'b00}) → RESP.
  - read_data is sampled at the end of the READ cycle.
- Word store: IDLE → WRITE → RESP.
  - In WRITE, sig_mem_write=1 for one cycle.
  - W = req_wdata, with the byte at offset 0 = req_wdata[31:24].
- Sub-word store: IDLE → READ → WRITE → RESP.
  - W = sampled word with the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0] (big-endian placement). All other bytes are preserved.
- sig_mem_read and sig_mem_write are never high together, and both are 0 outside READ and WRITE.
- mem_address is held stable from READ through WRITE.
- RESP: resp_valid=1 for one cycle, then back to IDLE. There is no response backpressure.
- Latency from the accept edge at cycle N:
  - Error: resp_valid at N+1.
  - Load or word store: resp_valid at N+2.
  - Sub-word store: resp_valid at N+3.
  - The next request can be accepted in the cycle after RESP.
- Load extraction:
  - Byte at offset k: read_data[31-8k -: 8].
  - Halfword at offset 0: read_data[31:16]. Halfword at offset 2: read_data[15:0].
  - Extended to 32 bits per req_signed.
- req_valid while not ready: ignored; the requester holds the request.

Test Plan:
1. Memory word at 0x10 reads 0x11223344; LW 0x10 accepted at N → sig_mem_read high only at N+1, mem_address=0x10; resp_valid at N+2, resp_rdata=0x11223344, resp_err=0.
2. Word at 0x10 = 0x112233C4; LB 0x13 signed → 0xFFFFFFC4. LBU 0x13 → 0x000000C4. LH 0x10 signed → 0x00001122.
3. SH 0x12 wdata 0x0000ABCD on 0x11223344 → READ at N+1, WRITE at N+2 with write_data=0xCDAB2211, resp at N+3. A following LW 0x10 returns 0x1122ABCD.
4. LW 0x11 → resp_valid at N+1 with resp_err=1 and resp_rdata=0; sig_mem_read and sig_mem_write stay 0 throughout. Same result for SW 0x3FE and LB with size=3.
5. SW 0x3FC wdata 0xDEADBEEF (ADDR_LIMIT 1024) → write_data=0xEFBEADDE, no error. SW 0x400 → error, no strobe.
6. SB 0x20 accepted, rst=1 on the READ-cycle edge → sig_mem_write never asserted, all outputs 0, req_ready=1 once rst is released; memory word at 0x20 unchanged.
